// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU types: FSM states, instruction field layout, field widths
package cpu_pkg;

  localparam int OPCODE_W   = 3;
  localparam int REG_ADDR_W = 2;

  // Instruction layout: [7:5] opcode, [4:3] rd, [2:1] rs, [0] reserved
  localparam int OPC_MSB  = 7;
  localparam int OPC_LSB  = 5;
  localparam int RD_MSB   = 4;
  localparam int RD_LSB   = 3;
  localparam int RS_MSB   = 2;
  localparam int RS_LSB   = 1;
  localparam int RSVD_BIT = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DECODE = 2'd2,
    EXEC   = 2'd3
  } state_t;

endpackage

// File: rtl/fetch_decode_unit_if.sv
// rtl/fetch_decode_unit_if.sv - instruction-memory request/valid bus
interface fetch_decode_unit_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 8
);
  logic               req;
  logic [ADDR_W-1:0]  addr;
  logic               valid;
  logic [INSTR_W-1:0] data;

  modport master (output req, output addr, input valid, input data);
  modport slave  (input req, input addr, output valid, output data);
endinterface

// File: rtl/program_counter.sv
// rtl/program_counter.sv - program counter with reset value and wrapping increment
module program_counter #(
  parameter int ADDR_W   = 8,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [ADDR_W-1:0] pc
);

  // Advance by one when enabled; wraps naturally at 2^ADDR_W
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= ADDR_W'(RESET_PC);
    end else if (en) begin
      pc <= pc + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_decode_unit.sv
// rtl/fetch_decode_unit.sv - instruction fetch/decode stage: PC, IR, FETCH/DECODE/EXEC sequencing
module fetch_decode_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int INSTR_W  = 8,
  parameter int RESET_PC = 0,
  parameter int TIMEOUT  = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  fetch_decode_unit_if.master   imem,
  output logic [OPCODE_W-1:0]   opcode,
  output logic [REG_ADDR_W-1:0] rd_addr,
  output logic [REG_ADDR_W-1:0] rs_addr,
  output logic                  instr_valid,
  output logic                  wb_en,
  output logic [ADDR_W-1:0]     pc,
  output logic                  busy,
  output logic                  err
);

  // Last count value before a fetch is declared timed out
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t             state;
  logic [INSTR_W-1:0] ir;
  logic [7:0]         tmo_cnt;
  logic               req_q;
  logic               unused_rsvd;

  program_counter #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk (clk),
    .rst (rst),
    .en  (state == EXEC),
    .pc  (pc)
  );

  // pc only changes in EXEC, so the address is stable for the whole fetch
  assign imem.req  = req_q;
  assign imem.addr = pc;

  assign opcode      = ir[OPC_MSB:OPC_LSB];
  assign rd_addr     = ir[RD_MSB:RD_LSB];
  assign rs_addr     = ir[RS_MSB:RS_LSB];
  assign unused_rsvd = ir[RSVD_BIT];
  assign busy        = (state != IDLE);

  // Instruction sequencer; IR, request, strobes and error are all registered here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ir          <= '0;
      tmo_cnt     <= '0;
      req_q       <= 1'b0;
      instr_valid <= 1'b0;
      wb_en       <= 1'b0;
      err         <= 1'b0;
    end else begin
      instr_valid <= 1'b0;
      wb_en       <= 1'b0;
      case (state)
        IDLE: begin
          if (run && !err) begin
            state   <= FETCH;
            req_q   <= 1'b1;
            tmo_cnt <= '0;
          end
        end
        FETCH: begin
          if (imem.valid) begin
            ir    <= imem.data;
            req_q <= 1'b0;
            state <= DECODE;
          end else if (tmo_cnt == TMO_LAST) begin
            err   <= 1'b1;
            req_q <= 1'b0;
            state <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        DECODE: begin
          state       <= EXEC;
          instr_valid <= 1'b1;
          wb_en       <= 1'b1;
        end
        EXEC: begin
          if (run) begin
            state   <= FETCH;
            req_q   <= 1'b1;
            tmo_cnt <= '0;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_decode_unit.sv
// tb/tb_fetch_decode_unit.sv - self-checking bench for fetch_decode_unit
module tb_fetch_decode_unit;

  logic       clk;
  logic       rst;
  logic       run;
  logic       imem_valid;
  logic [7:0] imem_data;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic [2:0] opcode;
  logic [1:0] rd_addr;
  logic [1:0] rs_addr;
  logic       instr_valid;
  logic       wb_en;
  logic [7:0] pc;
  logic       busy;
  logic       err;

  int n_checks = 0;
  int n_pass   = 0;

  // Transaction-level model: address of the next instruction to execute
  logic [7:0] m_pc;

  fetch_decode_unit_if #(.ADDR_W(8), .INSTR_W(8)) imem_bus ();

  assign imem_bus.valid = imem_valid;
  assign imem_bus.data  = imem_data;
  assign imem_req       = imem_bus.req;
  assign imem_addr      = imem_bus.addr;

  fetch_decode_unit #(
    .ADDR_W   (8),
    .INSTR_W  (8),
    .RESET_PC (0),
    .TIMEOUT  (15)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .imem        (imem_bus),
    .opcode      (opcode),
    .rd_addr     (rd_addr),
    .rs_addr     (rs_addr),
    .instr_valid (instr_valid),
    .wb_en       (wb_en),
    .pc          (pc),
    .busy        (busy),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got running required finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", tag, got, exp);
  endtask

  // Execute one instruction: memory answers after 'delay' wait cycles with 'data'.
  // run is dropped at wait cycle 'drop_at' (drop_at == delay: in the valid cycle; -1: never).
  task automatic exec_one(input logic [7:0] data, input int delay, input int drop_at);
    int n = 0;
    while (!imem_req && n < 4) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", imem_req, 1);
    chk("fetch_addr", imem_addr, m_pc);
    for (int i = 0; i < delay; i++) begin
      if (i == drop_at) run = 1'b0;
      @(negedge clk);
      chk("req_hold", imem_req, 1);
      chk("addr_hold", imem_addr, m_pc);
    end
    if (drop_at >= delay) run = 1'b0;
    imem_valid = 1'b1;
    imem_data  = data;
    @(negedge clk);
    imem_valid = 1'b0;
    imem_data  = 8'($urandom);
    chk("dec_busy", busy, 1);
    chk("dec_req", imem_req, 0);
    chk("dec_ivalid", instr_valid, 0);
    chk("dec_opcode", opcode, data[7:5]);
    chk("dec_rd", rd_addr, data[4:3]);
    chk("dec_rs", rs_addr, data[2:1]);
    @(negedge clk);
    chk("exe_ivalid", instr_valid, 1);
    chk("exe_wb_en", wb_en, 1);
    chk("exe_pc", pc, m_pc);
    chk("exe_opcode", opcode, data[7:5]);
    m_pc = m_pc + 8'd1;
    @(negedge clk);
    chk("post_ivalid", instr_valid, 0);
    chk("post_wb_en", wb_en, 0);
    chk("post_pc", pc, m_pc);
    chk("post_err", err, 0);
    if (run) begin
      chk("b2b_req", imem_req, 1);
      chk("b2b_addr", imem_addr, m_pc);
    end else begin
      chk("stop_busy", busy, 0);
      chk("stop_req", imem_req, 0);
    end
  endtask

  task automatic idle_then_resume(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      chk("idle_req", imem_req, 0);
      chk("idle_ivalid", instr_valid, 0);
      chk("idle_opcode_hold", opcode, opcode);
    end
    run = 1'b1;
    @(negedge clk);
    chk("resume_req", imem_req, 1);
    chk("resume_addr", imem_addr, m_pc);
  endtask

  initial begin
    int n;
    logic [7:0] d;
    int dl;
    int dr;

    rst        = 1'b1;
    run        = 1'b0;
    imem_valid = 1'b0;
    imem_data  = 8'h00;
    m_pc       = 8'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_pc", pc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_opcode", opcode, 0);
    chk("rst_ivalid", instr_valid, 0);
    chk("rst_wb_en", wb_en, 0);

    // Zero-wait A6: request in the cycle after run rises
    run = 1'b1;
    @(negedge clk);
    chk("first_req_latency", imem_req, 1);
    exec_one(8'hA6, 0, -1);
    chk("a6_pc", pc, 1);

    // Three wait cycles
    exec_one(8'h3C, 3, -1);
    chk("wait3_err", err, 0);

    // run dropped mid-wait: completes, then idles, resumes at next pc
    exec_one(8'h5A, 4, 2);
    idle_then_resume(3);

    // Randomized instruction stream
    for (int k = 0; k < 40; k++) begin
      d  = 8'($urandom);
      dl = int'($urandom_range(5));
      dr = ($urandom_range(3) == 0) ? int'($urandom_range(dl)) : -1;
      exec_one(d, dl, dr);
      if (!run) idle_then_resume(int'($urandom_range(4)));
    end

    // Longest wait that still succeeds: 14 empty fetch cycles
    exec_one(8'hE1, 14, -1);
    chk("wait14_err", err, 0);

    // Walk pc up to 255, then wrap
    while (m_pc != 8'd255) exec_one(8'($urandom), 0, -1);
    exec_one(8'h77, 0, -1);
    chk("wrap_pc", pc, 0);
    chk("wrap_addr", imem_addr, 0);

    // Memory never answers: 15 fetch cycles then sticky error
    n = 0;
    while (imem_req && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_fetch_cycles", n, 15);
    chk("tmo_err", err, 1);
    chk("tmo_req", imem_req, 0);
    chk("tmo_busy", busy, 0);
    chk("tmo_pc", pc, m_pc);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("err_run_ignored", busy, 0);
      chk("err_sticky", err, 1);
    end

    // Restart, then async reset in the middle of a fetch wait
    rst = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
    m_pc = 8'd0;
    @(negedge clk);
    chk("restart_req", imem_req, 1);
    chk("restart_err", err, 0);
    chk("restart_addr", imem_addr, 0);
    @(negedge clk);
    exec_one(8'hC8, 0, -1);
    @(negedge clk);
    chk("mid_fetch_req", imem_req, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_req", imem_req, 0);
    chk("async_pc", pc, 0);
    chk("async_busy", busy, 0);
    chk("async_opcode", opcode, 0);
    run  = 1'b0;
    m_pc = 8'd0;
    @(negedge clk);
    rst        = 1'b0;
    imem_valid = 1'b1;
    imem_data  = 8'hFF;
    @(negedge clk);
    @(negedge clk);
    imem_valid = 1'b0;
    chk("stray_valid_busy", busy, 0);
    chk("stray_valid_opcode", opcode, 0);
    chk("stray_valid_rd", rd_addr, 0);
    chk("stray_valid_ivalid", instr_valid, 0);
    chk("stray_valid_pc", pc, 0);

    run = 1'b1;
    @(negedge clk);
    exec_one(8'h92, 1, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
